// File: rtl/bottle_pkg.sv
// bottle_pkg: shared FSM state codes, BCD width, tone timing and BCD digit increment.
package bottle_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        HOLD = 3'd2,
        SWAP = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

    localparam int BCD_W    = 4;
    localparam int BEEP_DIV = 64;
    localparam int BEEP_LEN = 4096;

    // Returns {carry_out, digit}; a carry into 9 wraps the digit to 0.
    function automatic logic [BCD_W:0] bcd_digit_inc(input logic [BCD_W-1:0] d, input logic cin);
        return !cin ? {1'b0, d} : (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    endfunction
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up-counter with ripple carry, wrap at all-9s and sync clear.
module bcd_counter
    import bottle_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    input  logic                      clr,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic                      at_max
);
    logic [BCD_W*DIGITS-1:0] value_q, value_d;
    logic [BCD_W:0]          dig;
    logic                    carry;

    always_comb begin
        value_d = value_q;
        carry   = inc;
        dig     = '0;
        at_max  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_digit_inc(value_q[BCD_W*i +: BCD_W], carry);
            value_d[BCD_W*i +: BCD_W] = dig[BCD_W-1:0];
            carry  = dig[BCD_W];
            at_max = at_max & (value_q[BCD_W*i +: BCD_W] == 4'd9);
        end
        if (clr) value_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/bottle_fill_ctrl.sv
// bottle_fill_ctrl: pill-bottling controller counting pills per bottle against a BCD target.
// Optional tone generator on speaker when BOTTLE_BEEP_EN is defined (tied low otherwise).
module bottle_fill_ctrl
    import bottle_pkg::*;
#(
    parameter int TGT_DIGITS  = 2,
    parameter int BTL_DIGITS  = 3,
    parameter int SWAP_CYCLES = 16
) (
    input  logic                        CLK_org,
    input  logic                        RST_n,
    input  logic                        en_set,
    input  logic                        set_load,
    input  logic [BCD_W*TGT_DIGITS-1:0] set_digits,
    input  logic                        en_work,
    input  logic                        conti,
    input  logic                        bottle_ready,
    input  logic                        pill_pulse,
    input  logic                        clr,
    output logic [BCD_W*TGT_DIGITS-1:0] pill_cnt,
    output logic [BCD_W*BTL_DIGITS-1:0] bottle_cnt,
    output logic [2:0]                  state,
    output logic                        valve_open,
    output logic                        bottle_done,
    output logic                        err,
    output logic                        speaker
);
    localparam int SW = $clog2(SWAP_CYCLES + 1);

    state_e                        state_q, state_d;
    logic [BCD_W*TGT_DIGITS-1:0]   target_q, target_d, pill_nxt, set_clamped;
    logic [SW-1:0]                 swap_q, swap_d;
    logic                          seen_low_q, seen_low_d, valve_q, done_q, err_q, err_d;
    logic                          count, hit, stray, wait_done, pill_max, btl_max, c;
    logic [BCD_W:0]                dig;

    // Value the pill counter would take on this pulse, so completion is seen in the same cycle.
    always_comb begin
        pill_nxt    = '0;
        set_clamped = '0;
        dig         = '0;
        c           = 1'b1;
        for (int i = 0; i < TGT_DIGITS; i++) begin
            dig = bcd_digit_inc(pill_cnt[BCD_W*i +: BCD_W], c);
            pill_nxt[BCD_W*i +: BCD_W] = dig[BCD_W-1:0];
            c = dig[BCD_W];
            set_clamped[BCD_W*i +: BCD_W] = (set_digits[BCD_W*i +: BCD_W] > 4'd9) ? 4'd9 : set_digits[BCD_W*i +: BCD_W];
        end
    end

    assign count     = state_q == FILL && bottle_ready && pill_pulse && !clr;
    assign hit       = count && pill_nxt == target_q;
    assign stray     = pill_pulse && (state_q inside {SWAP, DONE, IDLE});
    assign wait_done = swap_q == SW'(SWAP_CYCLES);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (en_set && set_load) target_d = set_clamped;
                if (en_work && target_q == '0) state_d = ERR;
                else if (en_work && !en_set && bottle_ready) state_d = FILL;
            end
            FILL:    state_d = !bottle_ready ? ERR : hit ? SWAP : !en_work ? HOLD : FILL;
            HOLD:    state_d = !bottle_ready ? ERR : en_work ? FILL : HOLD;
            SWAP:    state_d = (wait_done && seen_low_q && bottle_ready) ? (conti ? FILL : DONE) : SWAP;
            DONE:    state_d = en_work ? DONE : IDLE;
            default: state_d = state_q;
        endcase
        if (clr) begin
            state_d  = IDLE;
            target_d = target_q;
        end
    end

    // The new-bottle handshake is only watched once the minimum closed time has elapsed.
    assign swap_d     = state_q != SWAP ? '0 : wait_done ? swap_q : swap_q + 1'b1;
    assign seen_low_d = state_q == SWAP && (seen_low_q || (wait_done && !bottle_ready));
    assign err_d      = !clr && (err_q || stray || (hit && btl_max) || state_d == ERR);

    always_ff @(posedge CLK_org or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            swap_q     <= '0;
            seen_low_q <= 1'b0;
            valve_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            swap_q     <= swap_d;
            seen_low_q <= seen_low_d;
            valve_q    <= state_d == FILL;
            done_q     <= hit;
            err_q      <= err_d;
        end
    end

    bcd_counter #(.DIGITS(TGT_DIGITS)) u_pill (
        .clk    (CLK_org),
        .rst_n  (RST_n),
        .inc    (count && !pill_max),
        .clr    (clr || hit),
        .value  (pill_cnt),
        .at_max (pill_max)
    );

    bcd_counter #(.DIGITS(BTL_DIGITS)) u_btl (
        .clk    (CLK_org),
        .rst_n  (RST_n),
        .inc    (hit),
        .clr    (clr),
        .value  (bottle_cnt),
        .at_max (btl_max)
    );

    assign state       = state_q;
    assign valve_open  = valve_q;
    assign bottle_done = done_q;
    assign err         = err_q;

`ifdef BOTTLE_BEEP_EN
    localparam int DW = $clog2(BEEP_DIV);
    localparam int LW = $clog2(BEEP_LEN + 1);

    logic [LW-1:0] beep_q, beep_d;
    logic [DW-1:0] div_q, div_d;
    logic          spk_q, spk_d, beep_on, tick;

    always_comb begin
        beep_on = state_q == ERR || beep_q != '0;
        tick    = div_q == (state_q == ERR ? DW'(BEEP_DIV / 2 - 1) : DW'(BEEP_DIV - 1));
        beep_d  = clr ? '0 : done_q ? LW'(BEEP_LEN) : (beep_q != '0) ? beep_q - 1'b1 : beep_q;
        div_d   = (!beep_on || done_q || tick) ? '0 : div_q + 1'b1;
        spk_d   = !beep_on ? 1'b0 : tick ? !spk_q : spk_q;
    end

    always_ff @(posedge CLK_org or negedge RST_n) begin
        if (!RST_n) begin
            beep_q <= '0;
            div_q  <= '0;
            spk_q  <= 1'b0;
        end else begin
            beep_q <= beep_d;
            div_q  <= div_d;
            spk_q  <= spk_d;
        end
    end

    assign speaker = spk_q;
`else
    assign speaker = 1'b0;
`endif
endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// tb_bottle_fill_ctrl: directed and randomized stimulus checked every cycle against a decimal reference model.
module tb_bottle_fill_ctrl;
    localparam int TD = 2;
    localparam int BD = 2;
    localparam int SC = 16;
    localparam int BMAX = 99;
    localparam int S_IDLE = 0, S_FILL = 1, S_HOLD = 2, S_SWAP = 3, S_DONE = 4, S_ERR = 5;

    logic            CLK_org = 1'b0;
    logic            RST_n = 1'b0;
    logic            en_set = 1'b0;
    logic            set_load = 1'b0;
    logic [4*TD-1:0] set_digits = '0;
    logic            en_work = 1'b0;
    logic            conti = 1'b0;
    logic            bottle_ready = 1'b0;
    logic            pill_pulse = 1'b0;
    logic            clr = 1'b0;
    logic [4*TD-1:0] pill_cnt;
    logic [4*BD-1:0] bottle_cnt;
    logic [2:0]      state;
    logic            valve_open, bottle_done, err, speaker;

    int checks = 0;
    int errors = 0;

    int m_tgt, m_pill, m_btl, m_st, m_swap;
    bit m_low, m_err, m_done, m_valve;

    bottle_fill_ctrl #(.TGT_DIGITS(TD), .BTL_DIGITS(BD), .SWAP_CYCLES(SC)) dut (
        .CLK_org(CLK_org), .RST_n(RST_n), .en_set(en_set), .set_load(set_load),
        .set_digits(set_digits), .en_work(en_work), .conti(conti), .bottle_ready(bottle_ready),
        .pill_pulse(pill_pulse), .clr(clr), .pill_cnt(pill_cnt), .bottle_cnt(bottle_cnt),
        .state(state), .valve_open(valve_open), .bottle_done(bottle_done), .err(err), .speaker(speaker)
    );

    always #5 CLK_org = ~CLK_org;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*TD-1:0] s);
        int v, p, d;
        v = 0;
        p = 1;
        for (int i = 0; i < TD; i++) begin
            d = int'(s[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_pill = 0; m_btl = 0; m_st = S_IDLE; m_swap = 0;
        m_low = 0; m_err = 0; m_done = 0; m_valve = 0;
    endtask

    task automatic complete_bottle();
        m_done = 1;
        m_pill = 0;
        m_st = S_SWAP;
        m_swap = 0;
        m_low = 0;
        if (m_btl == BMAX) begin
            m_btl = 0;
            m_err = 1;
        end else m_btl++;
    endtask

    task automatic model_step();
        m_done = 0;
        if (clr) begin
            m_pill = 0; m_btl = 0; m_err = 0; m_st = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE: begin
                    if (pill_pulse) m_err = 1;
                    if (en_work && m_tgt == 0) begin
                        m_st = S_ERR;
                        m_err = 1;
                    end else if (en_work && !en_set && bottle_ready) m_st = S_FILL;
                    if (en_set && set_load) m_tgt = clamp_val(set_digits);
                end
                S_FILL: begin
                    if (!bottle_ready) begin
                        m_st = S_ERR;
                        m_err = 1;
                    end else begin
                        if (pill_pulse) m_pill++;
                        if (pill_pulse && m_pill == m_tgt) complete_bottle();
                        else if (!en_work) m_st = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!bottle_ready) begin
                        m_st = S_ERR;
                        m_err = 1;
                    end else if (en_work) m_st = S_FILL;
                end
                S_SWAP: begin
                    if (pill_pulse) m_err = 1;
                    if (m_swap < SC) m_swap++;
                    else if (!bottle_ready) m_low = 1;
                    else if (m_low) m_st = conti ? S_FILL : S_DONE;
                end
                S_DONE: begin
                    if (pill_pulse) m_err = 1;
                    if (!en_work) m_st = S_IDLE;
                end
                default: ;
            endcase
        end
        m_valve = (m_st == S_FILL);
    endtask

    task automatic compare_all();
        check("pill_cnt", pill_cnt, to_bcd(m_pill));
        check("bottle_cnt", bottle_cnt, to_bcd(m_btl));
        check("state", state, m_st);
        check("valve_open", valve_open, m_valve);
        check("bottle_done", bottle_done, m_done);
        check("err", err, m_err);
        check("speaker", speaker, 0);
    endtask

    task automatic cycle();
        @(posedge CLK_org);
        model_step();
        @(negedge CLK_org);
        compare_all();
        pill_pulse = 1'b0;
        set_load = 1'b0;
        clr = 1'b0;
    endtask

    task automatic pills(input int n);
        repeat (n) begin
            pill_pulse = 1'b1;
            cycle();
            cycle();
        end
    endtask

    task automatic load(input logic [4*TD-1:0] v);
        en_set = 1'b1;
        set_digits = v;
        set_load = 1'b1;
        cycle();
        en_set = 1'b0;
    endtask

    task automatic swap_bottle(output int gap);
        gap = 0;
        bottle_ready = 1'b0;
        repeat (SC + 2) begin
            cycle();
            gap += int'(!valve_open);
        end
        bottle_ready = 1'b1;
        repeat (2) begin
            cycle();
            gap += int'(!valve_open);
        end
    endtask

    initial begin
        int gap;
        model_reset();
        repeat (2) @(negedge CLK_org);
        compare_all();
        RST_n = 1'b1;
        bottle_ready = 1'b1;

        // Single bottle, target 12, stop after one bottle
        load(8'h12);
        en_work = 1'b1;
        conti = 1'b0;
        cycle();
        check("in_fill", state, S_FILL);
        pills(11);
        check("pill_11", pill_cnt, 8'h11);
        pill_pulse = 1'b1;
        cycle();
        check("done_pulse", bottle_done, 1);
        check("swap_state", state, S_SWAP);
        cycle();
        check("done_one_cycle", bottle_done, 0);
        check("btl_1", bottle_cnt, 8'h01);
        swap_bottle(gap);
        check("to_done", state, S_DONE);
        en_work = 1'b0;
        cycle();

        // Continuous: three bottles of three
        clr = 1'b1;
        cycle();
        load(8'h03);
        conti = 1'b1;
        en_work = 1'b1;
        cycle();
        for (int b = 0; b < 3; b++) begin
            pills(3);
            if (b == 2) conti = 1'b0;
            swap_bottle(gap);
            check("swap_gap", gap >= SC, 1);
        end
        check("btl_3", bottle_cnt, 8'h03);
        en_work = 1'b0;
        cycle();

        // Hold and resume, target 10
        load(8'h10);
        en_work = 1'b1;
        cycle();
        pills(4);
        en_work = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pill_pulse = k[0];
            cycle();
        end
        check("hold_state", state, S_HOLD);
        check("hold_cnt", pill_cnt, 8'h04);
        en_work = 1'b1;
        cycle();
        pills(5);
        pill_pulse = 1'b1;
        cycle();
        check("hold_done", bottle_done, 1);
        swap_bottle(gap);
        en_work = 1'b0;
        cycle();

        // Faults: bottle removed mid-fill, clr, zero target
        en_work = 1'b1;
        cycle();
        pills(2);
        bottle_ready = 1'b0;
        cycle();
        check("err_state", state, S_ERR);
        check("err_flag", err, 1);
        check("err_valve", valve_open, 0);
        en_work = 1'b0;
        bottle_ready = 1'b1;
        clr = 1'b1;
        cycle();
        check("clr_idle", state, S_IDLE);
        en_work = 1'b1;
        cycle();
        check("target_kept", state, S_FILL);
        en_work = 1'b0;
        cycle();
        bottle_ready = 1'b0;
        cycle();
        clr = 1'b1;
        bottle_ready = 1'b1;
        cycle();
        load(8'h00);
        en_work = 1'b1;
        cycle();
        check("zero_tgt_err", state, S_ERR);
        en_work = 1'b0;
        clr = 1'b1;
        cycle();

        // Tally wrap after 100 bottles of one pill
        load(8'h01);
        conti = 1'b1;
        en_work = 1'b1;
        cycle();
        for (int b = 0; b < 100; b++) begin
            pills(1);
            if (b < 99) swap_bottle(gap);
        end
        check("wrap_cnt", bottle_cnt, 8'h00);
        check("wrap_err", err, 1);
        check("wrap_state", state, S_SWAP);
        swap_bottle(gap);
        check("wrap_continues", state, S_FILL);

        // Asynchronous reset between clock edges mid-fill
        clr = 1'b1;
        cycle();
        load(8'h05);
        cycle();
        pills(2);
        #2 RST_n = 1'b0;
        #1;
        check("arst_pill", pill_cnt, 0);
        check("arst_state", state, S_IDLE);
        check("arst_valve", valve_open, 0);
        model_reset();
        en_work = 1'b0;
        conti = 1'b0;
        @(negedge CLK_org);
        compare_all();
        RST_n = 1'b1;

        // Randomized operation, including nibble clamping
        for (int n = 0; n < 4000; n++) begin
            en_set = ($urandom % 8) == 0;
            set_load = ($urandom % 6) == 0;
            set_digits = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            en_work = ($urandom % 8) != 0;
            conti = 1'($urandom);
            if ($urandom % 12 == 0) bottle_ready = !bottle_ready;
            pill_pulse = ($urandom % 3) == 0;
            clr = ($urandom % 80) == 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bottle_fill_ctrl.md
Name: bottle_fill_ctrl

Overview:
- Parametrised next-generation pill-bottling controller: counts sensor pulses into the current bottle against a BCD target and sequences bottle swaps.
- Also tallies completed bottles and flags faults.
- Sits between the operator panel (BCD thumbwheel target, enable and set keys) and the display/speaker drivers.
- Generalises the fixed two-digit setting to N-digit targets and N-digit bottle tallies, and adds hold/resume, continuous mode and fault handling.

Parameters:
- TGT_DIGITS, 2, BCD digits in the per-bottle pill target and the pill counter.
- BTL_DIGITS, 3, BCD digits in the completed-bottle tally.
- SWAP_CYCLES, 16, minimum cycles the valve stays closed between bottles (≥1).

Ports:
- CLK_org  in  1  system clock; the block has one clock.
- RST_n  in  1  asynchronous active-low reset.
- en_set  in  1  set-mode enable.
- set_load  in  1  one-cycle strobe; latch set_digits as target.
- set_digits  in  4*TGT_DIGITS  BCD target, least significant digit in bits [3:0].
- en_work  in  1  run enable; low pauses the fill.
- conti  in  1  1 = auto-continue to next bottle; 0 = stop after one bottle.
- bottle_ready  in  1  bottle present under chute.
- pill_pulse  in  1  one-cycle pulse per pill passing the sensor.
- clr  in  1  synchronous clear of counters and error.
- pill_cnt  out  4*TGT_DIGITS  BCD pills in the current bottle.
- bottle_cnt  out  4*BTL_DIGITS  BCD completed bottles.
- state  out  3  current FSM state code.
- valve_open  out  1  chute valve command.
- bottle_done  out  1  one-cycle pulse on bottle completion.
- err  out  1  sticky fault flag.
- speaker  out  1  tone output (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, target 0, state IDLE.
- State encoding: IDLE=0, FILL=1, HOLD=2, SWAP=3, DONE=4, ERR=5.
- valve_open is a registered output, high only in FILL.
- Target load: en_set=1 & set_load=1 in IDLE latches set_digits. Ignored in any other state. Any nibble >9 is clamped to 9.
- IDLE→FILL: en_work=1, en_set=0, bottle_ready=1, target≠0. If en_work=1 with target=0, go to ERR.
- FILL, on pill_pulse: BCD increment pill_cnt with ripple carry. If the incremented value equals the target, in the same cycle:
  - go to SWAP;
  - drop valve_open;
  - pulse bottle_done;
  - BCD increment bottle_cnt. At all-9s it wraps to 0 and sets err, but the state does not change to ERR.
- FILL, en_work=0: go to HOLD. pill_cnt is held; a pill_pulse arriving in that same cycle is still counted.
- HOLD→FILL: en_work=1.
- FILL or HOLD, bottle_ready=0: go to ERR. Bottle removed mid-fill.
- SWAP: pill_cnt is cleared on entry. Wait SWAP_CYCLES cycles, then require the bottle_ready falling-then-rising sequence (new bottle).
  - conti=1: go to FILL.
  - conti=0: go to DONE.
- DONE→IDLE: en_work=0.
- Stray pill: pill_pulse in SWAP, DONE or IDLE sets err. The state is unchanged.
- ERR: valve closed, counters frozen. Only clr leaves ERR; it goes to IDLE.
- clr in any state: pill_cnt=0, bottle_cnt=0, err=0, state IDLE; target retained. clr has priority over all other inputs in the same cycle.
- Reset mid-operation: immediate return to reset values; target lost.

Optional Feature:
- Macro: BOTTLE_BEEP_EN.
- Defined:
  - speaker toggles every 64 CLK_org cycles for 4096 cycles after each bottle_done (restart if a new bottle_done arrives);
  - speaker toggles continuously every 32 cycles while in ERR.
- Undefined: speaker is tied to 0; no counter logic is synthesised.

Decomposition:
- Shared package bottle_pkg:
  - state enum/localparams (IDLE..ERR, 3 bits);
  - BCD digit width constant (4);
  - BEEP_DIV and BEEP_LEN constants.
- Sub-module bcd_counter, parametrised by DIGITS, with:
  - inputs: inc, clr;
  - outputs: value, at_max.
- bcd_counter is instantiated for pill_cnt and for bottle_cnt.
- Comparison against the target stays in the top level.

Test Plan:
- Load: en_set=1, set_load, set_digits=0x12 → target 12. Run with conti=0, 12 pill_pulses → pill_cnt reads 0x11 then completes; bottle_done for exactly 1 cycle; bottle_cnt=0x001; state SWAP then DONE after bottle swap.
- Continuous: target 03, conti=1, 3 bottles of 3 pulses with bottle swaps → bottle_cnt=0x003; valve_open low for ≥16 cycles between bottles.
- Hold: target 10, 4 pulses, en_work=0 for 20 cycles with pulses ignored (state HOLD, no err? — pulses in HOLD are not counted), then en_work=1 and 6 pulses → completion at exactly 10 counted pills.
- Faults:
  - bottle_ready dropped mid-FILL → ERR, err=1, valve_open=0;
  - clr → IDLE with counters 0 and target retained;
  - en_work with target 00 → ERR.
- Wrap: BTL_DIGITS=1, target 01, 10 bottles → bottle_cnt wraps 9→0 and err=1, while filling continues.
- Async reset asserted mid-FILL between clock edges → all outputs 0 immediately. With BOTTLE_BEEP_EN defined, speaker toggles at period 128 cycles after bottle_done.
